spi_csr_sequencer: RTL and testbench

- Sits between `spi_slave` and the CSR bank inside the expander core, in the `clk` domain.
- Synchronises the SPI byte-ready and slave-select signals into `clk`.
- Decodes each frame as a command byte followed by data bytes.
- Sequences CSR write/read strobes, with optional address auto-increment, and loads read data back into the SPI transmit register.

---
 rtl/spi_csr_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_spi_csr_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_csr_sequencer.sv
// spi_csr_sequencer
//   Bridges spi_slave and the CSR bank in the clk domain. It synchronises the
//   SPI byte-ready and slave-select signals and decodes each frame as one
//   command byte followed by data bytes. It then issues CSR write or read
//   strobes, with optional address auto-increment, and loads read data back
//   into the SPI transmit register.
//
//   Command byte: bit7 = write(1)/read(0), bit6 = auto-increment,
//                 bits[ADDR_W-1:0] = start address.
//
//   Optional feature (macro SEQ_STATUS_BYTE_EN): at frame start, load the
//   status byte {err_prev, 3'b000, NUM_REGS[3:0]} into tx_data and pulse
//   tx_latch.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   ss         SPI slave select, active-low, asynchronous
//   rx_rdy     byte-complete level from spi_slave, asynchronous
//   rx_data    received byte, stable while rx_rdy is high
//   tx_data    byte for spi_slave to shift out next
//   tx_latch   one-clk pulse: spi_slave loads tx_data
//   csr_addr   CSR address
//   csr_wdata  CSR write data
//   csr_we     one-clk write strobe
//   csr_re     one-clk read strobe (csr_rdata valid the following cycle)
//   csr_rdata  CSR read data
//   busy       high while a frame is being sequenced
//   err        sticky illegal-address flag, cleared at frame start

module spi_csr_sequencer #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              tx_latch,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [7:0]        csr_wdata,
    output logic              csr_we,
    output logic              csr_re,
    input  logic [7:0]        csr_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RD_REQ,
        RD_LOAD,
        RD_WAIT
    } state_t;

`ifdef SEQ_STATUS_BYTE_EN
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);
`endif

    state_t state;
    logic   ss_s1, ss_s2, ss_s3;
    logic   rdy_s1, rdy_s2, rdy_s3;
    logic   byte_evt;
    logic   frame_start;
    logic   frame_end;
    logic   addr_legal;
    logic   auto_inc;
    logic   inc_pend;
    logic   load_dly;

    // Two-flop synchronisers plus one flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_s1  <= 1'b1;
            ss_s2  <= 1'b1;
            ss_s3  <= 1'b1;
            rdy_s1 <= 1'b0;
            rdy_s2 <= 1'b0;
            rdy_s3 <= 1'b0;
        end else begin
            ss_s1  <= ss;
            ss_s2  <= ss_s1;
            ss_s3  <= ss_s2;
            rdy_s1 <= rx_rdy;
            rdy_s2 <= rdy_s1;
            rdy_s3 <= rdy_s2;
        end
    end

    assign byte_evt    = rdy_s2 & ~rdy_s3;
    assign frame_start = ss_s3 & ~ss_s2;
    assign frame_end   = ss_s2;
    assign addr_legal  = (32'(csr_addr) < NUM_REGS);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_data   <= '0;
            tx_latch  <= 1'b0;
            csr_addr  <= '0;
            csr_wdata <= '0;
            csr_we    <= 1'b0;
            csr_re    <= 1'b0;
            err       <= 1'b0;
            auto_inc  <= 1'b0;
            inc_pend  <= 1'b0;
            load_dly  <= 1'b0;
        end else begin
            csr_we   <= 1'b0;
            csr_re   <= 1'b0;
            tx_latch <= 1'b0;

            // Slave deselect aborts the frame and beats any same-cycle byte.
            if (state != IDLE && frame_end) begin
                state    <= IDLE;
                inc_pend <= 1'b0;
                load_dly <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_start) begin
                            state <= CMD;
                            err   <= 1'b0;
`ifdef SEQ_STATUS_BYTE_EN
                            tx_data  <= {err, 3'b000, NUM_REGS_B[3:0]};
                            tx_latch <= 1'b1;
`endif
                        end
                    end

                    CMD: begin
                        if (byte_evt) begin
                            csr_addr <= rx_data[ADDR_W-1:0];
                            auto_inc <= rx_data[6];
                            state    <= rx_data[7] ? WDATA : RD_REQ;
                        end
                    end

                    WDATA: begin
                        // Increment one cycle late so the strobe still sees
                        // the address it was issued for; bytes are never
                        // closer than two cycles apart.
                        if (inc_pend) begin
                            csr_addr <= csr_addr + 1'b1;
                            inc_pend <= 1'b0;
                        end
                        if (byte_evt) begin
                            csr_wdata <= rx_data;
                            if (addr_legal) begin
                                csr_we <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                            inc_pend <= auto_inc;
                        end
                    end

                    RD_REQ: begin
                        if (addr_legal) begin
                            csr_re <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        load_dly <= 1'b1;
                        state    <= RD_LOAD;
                    end

                    RD_LOAD: begin
                        // First cycle is the strobe cycle; read data is only
                        // valid in the cycle after it.
                        if (load_dly) begin
                            load_dly <= 1'b0;
                        end else begin
                            tx_data  <= addr_legal ? csr_rdata : 8'hFF;
                            tx_latch <= 1'b1;
                            state    <= RD_WAIT;
                        end
                    end

                    RD_WAIT: begin
                        if (byte_evt) begin
                            if (auto_inc) begin
                                csr_addr <= csr_addr + 1'b1;
                            end
                            state <= RD_REQ;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_csr_sequencer.sv
// tb_spi_csr_sequencer
//   Drives two sequencer instances (NUM_REGS = 12 and 16) with the same SPI
//   traffic. Expected CSR writes, reads and tx loads are queued as the
//   stimulus is issued and consumed as the DUTs produce them.

module tb_spi_csr_sequencer;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       ss      = 1'b1;
    logic       rx_rdy  = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic [7:0] tx_data12, tx_data16;
    logic       tx_latch12, tx_latch16;
    logic [3:0] addr12, addr16;
    logic [7:0] wdata12, wdata16;
    logic       we12, we16;
    logic       re12, re16;
    logic [7:0] rdata12, rdata16;
    logic       busy12, busy16;
    logic       err12, err16;

    always #5 clk = ~clk;

    spi_csr_sequencer #(.ADDR_W(4), .NUM_REGS(12)) dut12 (
        .clk(clk), .rst(rst), .ss(ss), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .tx_data(tx_data12), .tx_latch(tx_latch12), .csr_addr(addr12),
        .csr_wdata(wdata12), .csr_we(we12), .csr_re(re12),
        .csr_rdata(rdata12), .busy(busy12), .err(err12)
    );

    spi_csr_sequencer #(.ADDR_W(4), .NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst), .ss(ss), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .tx_data(tx_data16), .tx_latch(tx_latch16), .csr_addr(addr16),
        .csr_wdata(wdata16), .csr_we(we16), .csr_re(re16),
        .csr_rdata(rdata16), .busy(busy16), .err(err16)
    );

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq12[$], wq16[$];
    logic [3:0] rq12[$], rq16[$];
    logic [7:0] tq12[$], tq16[$];
    wr_t        w12m, w16m;
    logic [3:0] r12m, r16m;
    logic [7:0] t12m, t16m;

    int   checks       = 0;
    int   failures     = 0;
    int   cyc          = 0;
    int   last_rdy_cyc = 0;
    int   we_cyc12     = 0;
    logic exp_err12    = 1'b0;
    logic exp_err16    = 1'b0;

    logic [7:0] mem12 [16];
    logic [7:0] mem16 [16];

    function automatic logic [7:0] init_val(input int unsigned i);
        if (i == 2) return 8'hA5;
        if (i == 3) return 8'h3C;
        return 8'(32'h10 + i);
    endfunction

    // CSR bank model: registered read data, valid the cycle after csr_re.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                mem12[i] <= init_val(i);
                mem16[i] <= init_val(i);
            end
            rdata12 <= '0;
            rdata16 <= '0;
        end else begin
            if (we12) mem12[addr12] <= wdata12;
            if (re12) rdata12 <= mem12[addr12];
            if (we16) mem16[addr16] <= wdata16;
            if (re16) rdata16 <= mem16[addr16];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (!rst) begin
            if (we12) begin
                we_cyc12 = cyc;
                if (wq12.size() == 0) check("we12_unexpected", 32'(wq12.size()), 1);
                else begin
                    w12m = wq12.pop_front();
                    check("we12_addr", 32'(addr12), 32'(w12m.addr));
                    check("we12_data", 32'(wdata12), 32'(w12m.data));
                end
            end
            if (we16) begin
                if (wq16.size() == 0) check("we16_unexpected", 32'(wq16.size()), 1);
                else begin
                    w16m = wq16.pop_front();
                    check("we16_addr", 32'(addr16), 32'(w16m.addr));
                    check("we16_data", 32'(wdata16), 32'(w16m.data));
                end
            end
            if (re12) begin
                if (rq12.size() == 0) check("re12_unexpected", 32'(rq12.size()), 1);
                else begin
                    r12m = rq12.pop_front();
                    check("re12_addr", 32'(addr12), 32'(r12m));
                end
            end
            if (re16) begin
                if (rq16.size() == 0) check("re16_unexpected", 32'(rq16.size()), 1);
                else begin
                    r16m = rq16.pop_front();
                    check("re16_addr", 32'(addr16), 32'(r16m));
                end
            end
            if (tx_latch12) begin
                if (tq12.size() == 0) check("tx12_unexpected", 32'(tq12.size()), 1);
                else begin
                    t12m = tq12.pop_front();
                    check("tx12_data", 32'(tx_data12), 32'(t12m));
                end
            end
            if (tx_latch16) begin
                if (tq16.size() == 0) check("tx16_unexpected", 32'(tq16.size()), 1);
                else begin
                    t16m = tq16.pop_front();
                    check("tx16_data", 32'(tx_data16), 32'(t16m));
                end
            end
            if (we12 && (re12 || tx_latch12)) check("strobe_overlap12", 32'({we12, re12, tx_latch12}), 32'({we12, 2'b00}));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_rdy       = 1'b1;
        last_rdy_cyc = cyc;
        repeat (6) @(negedge clk);
        rx_rdy = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_begin();
`ifdef SEQ_STATUS_BYTE_EN
        tq12.push_back({exp_err12, 7'h0C});
        tq16.push_back({exp_err16, 7'h00});
`endif
        @(negedge clk);
        ss        = 1'b0;
        exp_err12 = 1'b0;
        exp_err16 = 1'b0;
        repeat (5) @(negedge clk);
        check("err12_cleared", 32'(err12), 0);
        check("busy12_start", 32'(busy12), 1);
    endtask

    task automatic frame_stop();
        @(negedge clk);
        ss = 1'b1;
        repeat (5) @(negedge clk);
        check("busy12_end", 32'(busy12), 0);
        check("busy16_end", 32'(busy16), 0);
    endtask

    task automatic drained(input string tag);
        check(tag, 32'(wq12.size() + wq16.size() + rq12.size() + rq16.size()
                       + tq12.size() + tq16.size()), 0);
    endtask

    task automatic check_err();
        check("err12", 32'(err12), 32'(exp_err12));
        check("err16", 32'(err16), 32'(exp_err16));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst12_outputs", 32'({tx_data12, tx_latch12, addr12, wdata12, we12, re12, busy12, err12}), 0);
        check("rst16_outputs", 32'({tx_data16, tx_latch16, addr16, wdata16, we16, re16, busy16, err16}), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Burst read with auto-increment from address 2.
        frame_begin();
        rq12.push_back(4'd2); rq16.push_back(4'd2);
        tq12.push_back(8'hA5); tq16.push_back(8'hA5);
        send_byte(8'h42);
        rq12.push_back(4'd3); rq16.push_back(4'd3);
        tq12.push_back(8'h3C); tq16.push_back(8'h3C);
        send_byte(8'h00);
        rq12.push_back(4'd4); rq16.push_back(4'd4);
        tq12.push_back(8'h14); tq16.push_back(8'h14);
        send_byte(8'h00);
        frame_stop();
        drained("burst_drain");
        check_err();

        // Read of address 13: illegal only for the 12-register instance.
        frame_begin();
        rq16.push_back(4'd13);
        tq16.push_back(8'h1D);
        tq12.push_back(8'hFF);
        exp_err12 = 1'b1;
        send_byte(8'h0D);
        frame_stop();
        drained("illegal_read_drain");
        check_err();

        // Single write 0x5A to address 3, with strobe latency.
        frame_begin();
        send_byte(8'h83);
        wq12.push_back(wr_t'{4'd3, 8'h5A}); wq16.push_back(wr_t'{4'd3, 8'h5A});
        send_byte(8'h5A);
        check("we_latency", 32'(we_cyc12 - last_rdy_cyc), 3);
        frame_stop();
        drained("single_write_drain");
        check_err();

        // Auto-increment write from 15 wrapping to 0.
        frame_begin();
        send_byte(8'hCF);
        wq16.push_back(wr_t'{4'd15, 8'h11});
        exp_err12 = 1'b1;
        send_byte(8'h11);
        wq12.push_back(wr_t'{4'd0, 8'h22}); wq16.push_back(wr_t'{4'd0, 8'h22});
        send_byte(8'h22);
        frame_stop();
        drained("wrap_drain");
        check_err();

        // Abort: ss rises together with a data byte in WDATA.
        frame_begin();
        send_byte(8'h85);
        @(negedge clk);
        rx_data = 8'h99;
        rx_rdy  = 1'b1;
        ss      = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_busy12", 32'(busy12), 0);
        check("abort_busy16", 32'(busy16), 0);
        repeat (3) @(negedge clk);
        rx_rdy = 1'b0;
        repeat (6) @(negedge clk);
        drained("abort_drain");
        check_err();

        // Reset mid-frame while a data byte is in flight.
        frame_begin();
        send_byte(8'h81);
        @(negedge clk);
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst12_outputs", 32'({tx_data12, tx_latch12, addr12, wdata12, we12, re12, busy12, err12}), 0);
        check("midrst16_outputs", 32'({tx_data16, tx_latch16, addr16, wdata16, we16, re16, busy16, err16}), 0);
        @(negedge clk);
        ss     = 1'b1;
        rx_rdy = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        exp_err12 = 1'b0;
        exp_err16 = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h44);
        drained("post_rst_drain");
        check("post_rst_busy12", 32'(busy12), 0);

        // New frame after reset works normally.
        frame_begin();
        send_byte(8'h87);
        wq12.push_back(wr_t'{4'd7, 8'hE1}); wq16.push_back(wr_t'{4'd7, 8'hE1});
        send_byte(8'hE1);
        frame_stop();
        drained("final_drain");
        check_err();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
